stream_unpacker: RTL and testbench



---
 rtl/stream_pkg.sv | 17 +
 rtl/stream_unpacker_lane_pick.sv | 38 +++
 rtl/stream_unpacker.sv | 93 +++++++++
 tb/tb_stream_unpacker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters: lane-mask bit tricks.
package stream_pkg;

    // Widest lane mask the helpers accept; callers zero-extend narrower masks.
    localparam int MASK_W = 64;

    // One-hot of the lowest set bit (all zeros when the mask is empty).
    function automatic logic [MASK_W-1:0] lowest_set(input logic [MASK_W-1:0] mask);
        return mask & (~mask + MASK_W'(1));
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic logic is_onehot(input logic [MASK_W-1:0] mask);
        return (mask != '0) && ((mask & (mask - MASK_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/stream_unpacker_lane_pick.sv
// Combinational lane selector: picks the lowest enabled lane of the held word
// and produces the mask that remains once that lane has been emitted.
module lane_pick
    import stream_pkg::*;
#(
    parameter int NARROW_WIDTH = 8,
    parameter int RATIO        = 4
) (
    input  logic [NARROW_WIDTH*RATIO-1:0] hold_data,
    input  logic [RATIO-1:0]              hold_keep,
    output logic [NARROW_WIDTH-1:0]       lane_data,
    output logic [RATIO-1:0]              pick_onehot,
    output logic [RATIO-1:0]              next_mask
);

    logic [NARROW_WIDTH-1:0] masked_lane [RATIO];

    // Lowest set bit; upper bits of the wide helper result are always zero.
    assign pick_onehot = RATIO'(lowest_set(MASK_W'(hold_keep)));
    assign next_mask   = hold_keep & ~pick_onehot;

    // One-hot AND-OR mux: works for any RATIO, no index arithmetic involved.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign masked_lane[gi] = pick_onehot[gi] ?
                hold_data[gi*NARROW_WIDTH +: NARROW_WIDTH] : '0;
        end
    endgenerate

    // OR-reduce the gated lanes into the output beat.
    always_comb begin
        lane_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            lane_data = lane_data | masked_lane[i];
        end
    end

endmodule

// File: rtl/stream_unpacker.sv
// Valid/ready width downsizer: holds one wide word and emits its enabled lanes
// lowest-first as narrow beats, one per cycle, with no bubble between words.
module stream_unpacker
    import stream_pkg::*;
#(
    parameter int NARROW_WIDTH = 8,
    parameter int RATIO        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NARROW_WIDTH*RATIO-1:0] s_data,
    input  logic [RATIO-1:0]              s_keep,
    input  logic                          s_last,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [NARROW_WIDTH-1:0]       m_data,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          drop_last
);

    localparam int DATA_W = NARROW_WIDTH * RATIO;

    logic [DATA_W-1:0] hold_data_reg, hold_data_next;
    logic [RATIO-1:0]  hold_keep_reg, hold_keep_next;
    logic              hold_last_reg, hold_last_next;
    logic              drop_last_reg, drop_last_next;

    logic [RATIO-1:0]  pick_onehot;
    logic [RATIO-1:0]  next_mask;
    logic              one_left;
    logic              in_hs;
    logic              out_hs;

    lane_pick #(
        .NARROW_WIDTH (NARROW_WIDTH),
        .RATIO        (RATIO)
    ) u_lane_pick (
        .hold_data   (hold_data_reg),
        .hold_keep   (hold_keep_reg),
        .lane_data   (m_data),
        .pick_onehot (pick_onehot),
        .next_mask   (next_mask)
    );

    assign one_left  = is_onehot(MASK_W'(hold_keep_reg));
    assign m_valid   = |hold_keep_reg;
    assign m_last    = hold_last_reg & one_left;
    // Ready depends only on state and m_ready, never on s_valid.
    assign s_ready   = ~m_valid | (m_ready & one_left);
    assign in_hs     = s_valid & s_ready;
    assign out_hs    = m_valid & m_ready;
    assign drop_last = drop_last_reg;

    // Next-state: clear the emitted lane, but a newly accepted word wins.
    always_comb begin
        hold_data_next = hold_data_reg;
        hold_keep_next = hold_keep_reg;
        hold_last_next = hold_last_reg;
        drop_last_next = in_hs & s_last & (s_keep == '0);
        if (out_hs) begin
            hold_keep_next = next_mask;
        end
        if (in_hs) begin
            hold_data_next = s_data;
            hold_keep_next = s_keep;
            hold_last_next = s_last;
        end
    end

    // Control state: reset discards any remaining lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_keep_reg <= '0;
            drop_last_reg <= 1'b0;
        end else begin
            hold_keep_reg <= hold_keep_next;
            drop_last_reg <= drop_last_next;
        end
    end

    // Payload state: only meaningful while lanes remain, so left unreset.
    always_ff @(posedge clk) begin
        hold_data_reg <= hold_data_next;
        hold_last_reg <= hold_last_next;
    end

    // pick_onehot is consumed inside lane_pick; keep it observable here too.
    logic unused_pick;
    assign unused_pick = ^pick_onehot;

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker (NARROW_WIDTH=8, RATIO=4).
module tb_stream_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        drop_last;

    int errors = 0;
    int checks = 0;

    stream_unpacker #(.NARROW_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .drop_last (drop_last)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge (inputs are driven here).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;
        step(); step();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++;
        if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        checks++;
        if (drop_last !== 1'b0) begin errors++; $display("FAIL reset_drop_last: got %b expected 0", drop_last); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        $display("test_reset done");
    endtask

    task automatic test_full_word();
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b1;
        step();
        put_word(32'h44332211, 4'b1111, 1'b1);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL full_accept_ready: got %b expected 1", s_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            s_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== (i == 3) || s_ready !== (i == 3)) begin
                errors++;
                $display("FAIL full_beat%0d: got v=%b d=%h l=%b r=%b expected v=1 d=%h l=%b r=%b",
                         i, m_valid, m_data, m_last, s_ready, exp_d[i], (i == 3), (i == 3));
            end
        end
        step();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL full_idle: got %b expected 0", m_valid); end
        $display("test_full_word done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        m_ready = 1'b1;
        step();
        put_word(32'h44332211, 4'b1111, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 4) put_word(32'h88776655, 4'b1111, 1'b1);
            else       s_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== (i == 7) || s_ready !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b r=%b expected v=1 d=%h l=%b r=%b",
                         i, m_valid, m_data, m_last, s_ready, exp_d[i], (i == 7), (i == 3 || i == 7));
            end
        end
        step();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", m_valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_sparse();
        m_ready = 1'b1;
        step();
        put_word(32'hDDCCBBAA, 4'b1010, 1'b1);
        step();
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hBB || m_last !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL sparse_bb: got v=%b d=%h l=%b r=%b expected v=1 d=bb l=0 r=0", m_valid, m_data, m_last, s_ready);
        end
        step();
        put_word(32'h000000EE, 4'b0001, 1'b1);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hDD || m_last !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL sparse_dd: got v=%b d=%h l=%b r=%b expected v=1 d=dd l=1 r=1", m_valid, m_data, m_last, s_ready);
        end
        step();
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hEE || m_last !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL sparse_ee: got v=%b d=%h l=%b r=%b expected v=1 d=ee l=1 r=1", m_valid, m_data, m_last, s_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL sparse_idle: got %b expected 0", m_valid); end
        $display("test_sparse done");
    endtask

    task automatic test_stall();
        logic       rdy   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp_d [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
        int hs = 0;
        m_ready = 1'b1;
        step();
        put_word(32'h44332211, 4'b1111, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            s_valid = 1'b0;
            m_ready = rdy[i];
            @(negedge clk);
            if (m_valid === 1'b1 && m_ready === 1'b1) hs++;
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_cyc%0d: got v=%b d=%h l=%b expected v=1 d=%h l=0", i, m_valid, m_data, m_last, exp_d[i]);
            end
        end
        step();
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", m_valid); end
        checks++;
        if (hs != 4) begin errors++; $display("FAIL stall_handshakes: got %0d expected 4", hs); end
        $display("test_stall done");
    endtask

    task automatic test_drop_last();
        m_ready = 1'b1;
        step();
        put_word(32'h12345678, 4'b0000, 1'b0);
        step();
        put_word(32'h00000000, 4'b0000, 1'b1);
        @(negedge clk);
        checks++;
        if (drop_last !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_nolast: got dl=%b v=%b r=%b expected dl=0 v=0 r=1", drop_last, m_valid, s_ready);
        end
        step();
        put_word(32'h0000005A, 4'b0001, 1'b0);
        @(negedge clk);
        checks++;
        if (drop_last !== 1'b1 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse: got dl=%b v=%b r=%b expected dl=1 v=0 r=1", drop_last, m_valid, s_ready);
        end
        step();
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (drop_last !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h5A || m_last !== 1'b0) begin
            errors++;
            $display("FAIL drop_next_beat: got dl=%b v=%b d=%h l=%b expected dl=0 v=1 d=5a l=0", drop_last, m_valid, m_data, m_last);
        end
        step();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || drop_last !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got v=%b dl=%b expected v=0 dl=0", m_valid, drop_last);
        end
        $display("test_drop_last done");
    endtask

    task automatic test_reset_midword();
        logic [7:0] exp_d [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        m_ready = 1'b1;
        step();
        put_word(32'h44332211, 4'b1111, 1'b1);
        step();
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h11) begin
            errors++;
            $display("FAIL rstmid_first: got v=%b d=%h expected v=1 d=11", m_valid, m_data);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || drop_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flush: got v=%b r=%b dl=%b expected v=0 r=1 dl=0", m_valid, s_ready, drop_last);
        end
        step();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || drop_last !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: got v=%b dl=%b expected v=0 dl=0", m_valid, drop_last);
        end
        step();
        put_word(32'h0D0C0B0A, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            s_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== (i == 3)) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         i, m_valid, m_data, m_last, exp_d[i], (i == 3));
            end
        end
        $display("test_reset_midword done");
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_sparse();
        test_stall();
        test_drop_last();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
